// File: rtl/div_unit_if.sv
// div_unit_if: request/response bundle between the execute stage and the divider.
// Latency: none, wires only.
// Backpressure: the requester must hold off while div_busy_o is high; starts are dropped then.
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic               div_sign;
    logic               div_start_i;
    logic               div_annul_i;
    logic [WIDTH-1:0]   div_op1;
    logic [WIDTH-1:0]   div_op2;
    logic               div_busy_o;
    logic               div_ready_o;
    logic [2*WIDTH-1:0] result;

    // Execute stage side
    modport master (
        output div_sign, div_start_i, div_annul_i, div_op1, div_op2,
        input  div_busy_o, div_ready_o, result
    );

    // Divider side
    modport slave (
        input  div_sign, div_start_i, div_annul_i, div_op1, div_op2,
        output div_busy_o, div_ready_o, result
    );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider, signed/unsigned, result {rem, quo}.
// Latency: ready pulse 34 cycles after start is sampled (2 for divide-by-zero with DIV_BYZERO_FAST_EN).
// Backpressure: div_busy_o high while working; starts during busy are dropped, annul aborts.
// Build option: define DIV_BYZERO_FAST_EN to short-cut divide-by-zero through DIV_ZERO.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DIV_ON   = 2'd1,
        S_DIV_END  = 2'd2,
        S_DIV_ZERO = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH:0]     r_rem;      // partial remainder, one spare bit for the trial
    logic [WIDTH-1:0]   r_quo;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   r_dvs;      // divisor magnitude
    logic [WIDTH-1:0]   r_op1_raw;  // untouched dividend for the divide-by-zero result
    logic               r_sign_q;
    logic               r_sign_r;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_result;
    logic               r_ready;

    logic               w_neg1;
    logic               w_neg2;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_start;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_trial;
    logic               w_ge;
    logic               w_last;
    logic [WIDTH-1:0]   w_rem_out;
    logic [WIDTH-1:0]   w_quo_out;
    logic [2*WIDTH-1:0] w_end_result;
    logic [2*WIDTH-1:0] w_zero_result;

    // Operand magnitudes; the most negative value maps onto itself and is then treated as unsigned.
    assign w_neg1  = bus.div_sign & bus.div_op1[WIDTH-1];
    assign w_neg2  = bus.div_sign & bus.div_op2[WIDTH-1];
    assign w_abs1  = w_neg1 ? -bus.div_op1 : bus.div_op1;
    assign w_abs2  = w_neg2 ? -bus.div_op2 : bus.div_op2;
    assign w_start = bus.div_start_i & ~bus.div_annul_i;

    // One restoring step: shift, trial-subtract, keep the trial if it did not go negative.
    assign w_shift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
    assign w_ge    = ~w_trial[WIDTH+1];
    assign w_last  = (r_cnt == CW'(WIDTH - 1));

    assign w_rem_out     = r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    assign w_quo_out     = r_sign_q ? -r_quo : r_quo;
    assign w_zero_result = {r_op1_raw, {WIDTH{1'b1}}};

`ifdef DIV_BYZERO_FAST_EN
    // Zero divisors never reach DIV_END in this build.
    assign w_end_result = {w_rem_out, w_quo_out};
`else
    logic r_zero;

    // Remember a zero divisor so DIV_END can substitute the fixed result.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_zero <= 1'b0;
        else if (r_state == S_IDLE && w_start)
            r_zero <= (bus.div_op2 == '0);
    end

    assign w_end_result = r_zero ? w_zero_result : {w_rem_out, w_quo_out};
`endif

    // Next-state: annul in any working state drops straight back to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
`ifdef DIV_BYZERO_FAST_EN
                    w_next = (bus.div_op2 == '0) ? S_DIV_ZERO : S_DIV_ON;
`else
                    w_next = S_DIV_ON;
`endif
                end
            end
            S_DIV_ON:   if (w_last) w_next = S_DIV_END;
            S_DIV_END:  w_next = S_IDLE;
            S_DIV_ZERO: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (r_state != S_IDLE && bus.div_annul_i)
            w_next = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Datapath: operand capture, iteration, and result/ready update.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_op1_raw <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_rem     <= '0;
                        r_quo     <= w_abs1;
                        r_dvs     <= w_abs2;
                        r_op1_raw <= bus.div_op1;
                        r_sign_q  <= w_neg1 ^ w_neg2;
                        r_sign_r  <= w_neg1;
                        r_cnt     <= '0;
                    end
                end
                S_DIV_ON: begin
                    r_rem <= w_ge ? w_trial[WIDTH:0] : w_shift;
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_DIV_END: begin
                    if (!bus.div_annul_i) begin
                        r_result <= w_end_result;
                        r_ready  <= 1'b1;
                    end
                end
                S_DIV_ZERO: begin
                    if (!bus.div_annul_i) begin
                        r_result <= w_zero_result;
                        r_ready  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.div_busy_o  = (r_state != S_IDLE);
    assign bus.div_ready_o = r_ready;
    assign bus.result      = r_result;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference.
// Latency: n/a.
// Backpressure: stimulus waits on div_ready_o with a bounded cycle budget.
module tb_div_unit;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    logic [63:0] last_res;

    div_unit_if #(.WIDTH(32)) bus ();
    div_unit #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; C-style truncation gives the MIPS sign rules.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int ref_lat(input logic [31:0] b);
`ifdef DIV_BYZERO_FAST_EN
        return (b == 32'd0) ? 2 : 34;
`else
        return (b == 32'd0) ? 34 : 34;
`endif
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.div_op1 = a;
        bus.div_op2 = b;
        bus.div_sign = s;
        bus.div_start_i = 1'b1;
        @(posedge clk); #1;
        bus.div_start_i = 1'b0;
    endtask

    // Returns in the ready cycle (or after the budget runs out).
    task automatic wait_done(input string tag, input logic [63:0] exp, input int exp_lat, input bit poke);
        int lat = 1;
        bit busy_bad = 0;
        bit done = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bus.div_ready_o) done = 1;
            else if (!bus.div_busy_o) busy_bad = 1;
            if (poke && lat == 5) begin
                bus.div_op1 = $urandom;
                bus.div_op2 = $urandom_range(1, 50);
                bus.div_start_i = 1'b1;
            end
            if (poke && lat == 6) bus.div_start_i = 1'b0;
        end
        chk({tag, "/lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "/res"}, bus.result, exp);
        chk({tag, "/busy_during"}, 64'(busy_bad), 64'd0);
        if (done) chk({tag, "/busy_at_ready"}, 64'(bus.div_busy_o), 64'd0);
        last_res = exp;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s, input bit poke);
        launch(a, b, s);
        wait_done(tag, ref_div(a, b, s), ref_lat(b), poke);
    endtask

    logic [31:0] d_a [7] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'h12345678, 32'd0};
    logic [31:0] d_b [7] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5};
    logic        d_s [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [31:0] a, b;
        logic s;
        bit saw_ready;
        bus.div_sign = 1'b0;
        bus.div_start_i = 1'b0;
        bus.div_annul_i = 1'b0;
        bus.div_op1 = '0;
        bus.div_op2 = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst/busy", 64'(bus.div_busy_o), 64'd0);
        chk("rst/ready", 64'(bus.div_ready_o), 64'd0);
        chk("rst/result", bus.result, 64'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Spot-check literal expectations for the directed corner cases
        chk("ref/unsigned", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("ref/ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'd0, 32'h80000000});

        // Directed cases, each launched in the ready cycle of the previous one
        for (int i = 0; i < 7; i++)
            run_op($sformatf("dir%0d", i), d_a[i], d_b[i], d_s[i], (i == 0));

        // Ready is a single-cycle pulse and the result holds
        @(posedge clk); #1;
        chk("pulse/ready_low", 64'(bus.div_ready_o), 64'd0);
        chk("pulse/hold", bus.result, last_res);

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF;
                3:       b = $urandom & 32'h0000FFFF;
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), a, b, s, (i % 5 == 2));
        end

        // Annul mid-division, with a start held across the annul edge
        launch(32'd100, 32'd7, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        bus.div_annul_i = 1'b1;
        bus.div_op1 = 32'd1000;
        bus.div_op2 = 32'd10;
        bus.div_sign = 1'b0;
        bus.div_start_i = 1'b1;
        @(posedge clk); #1;
        chk("annul/busy", 64'(bus.div_busy_o), 64'd0);
        chk("annul/ready", 64'(bus.div_ready_o), 64'd0);
        bus.div_annul_i = 1'b0;
        @(posedge clk); #1;
        bus.div_start_i = 1'b0;
        chk("annul/hold", bus.result, last_res);
        chk("annul/restart_busy", 64'(bus.div_busy_o), 64'd1);
        wait_done("annul_new", ref_div(32'd1000, 32'd10, 1'b0), 34, 1'b0);

        // Annul in IDLE blocks a simultaneous start
        bus.div_op1 = 32'd55;
        bus.div_op2 = 32'd5;
        bus.div_start_i = 1'b1;
        bus.div_annul_i = 1'b1;
        @(posedge clk); #1;
        bus.div_start_i = 1'b0;
        bus.div_annul_i = 1'b0;
        chk("idle_annul/busy", 64'(bus.div_busy_o), 64'd0);
        @(posedge clk); #1;
        chk("idle_annul/ready", 64'(bus.div_ready_o), 64'd0);

        // Reset in the middle of a division
        launch(32'd100, 32'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        chk("midrst/busy", 64'(bus.div_busy_o), 64'd0);
        chk("midrst/result", bus.result, 64'd0);
        chk("midrst/ready", 64'(bus.div_ready_o), 64'd0);
        resetn = 1'b1;
        saw_ready = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.div_ready_o) saw_ready = 1;
        end
        chk("midrst/no_ready", 64'(saw_ready), 64'd0);

        // Fresh division after reset
        run_op("post_rst", 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
